// File: rtl/xor_unit_arbiter_if.sv
// Request/response bundle for the shared XOR datapath.
// The requesters and the consumer take the master side; the arbiter takes the slave side.
interface xor_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_inv;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [WIDTH-1:0]         resp_data;
    logic [IDW-1:0]           resp_id;

    modport master (
        output req_valid, req_a, req_b, req_inv, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_inv, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one registered XOR/XNOR datapath between NUM_REQ requesters,
// with a valid/ready response port and a saturating completed-operation counter.
module xor_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2,
    parameter int CNTW    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    xor_unit_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [CNTW-1:0]      op_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic               acc;
    logic               gnt_found;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     scan_idx;
    logic               xfer;
    logic               done;
    logic [NUM_REQ-1:0] grant_vec;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   xor_res;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Scan from the highest offset down so the requester closest to ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = ptr_q + IDW'(k);
            if (bus.req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        acc       = (state_q == IDLE) || bus.resp_ready;
        xfer      = acc && gnt_found && reset_n;
        done      = (state_q == HOLD) && bus.resp_ready;
        grant_vec = '0;
        if (xfer) begin
            grant_vec[gnt_idx] = 1'b1;
        end
        op_a    = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
        op_b    = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
        xor_res = bus.req_inv[gnt_idx] ? ~(op_a ^ op_b) : (op_a ^ op_b);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (done) begin
            cnt_d   = sat_inc(cnt_q);
            state_d = IDLE;
        end
        if (xfer) begin
            state_d = HOLD;
            data_d  = xor_res;
            id_d    = gnt_idx;
            ptr_d   = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready  = grant_vec;
    assign bus.resp_valid = (state_q == HOLD);
    assign bus.resp_data  = data_q;
    assign bus.resp_id    = id_q;
    assign busy           = (state_q == HOLD);
    assign op_count       = cnt_q;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Scoreboard bench for xor_unit_arbiter: expected responses are queued by the stimulus
// and a negedge monitor pops and compares on every completed response handshake.
module tb_xor_unit_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic busy, busy2;
    logic [15:0] op_count;
    logic [3:0]  op_count2;

    always #5 clk = ~clk;

    xor_unit_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .IDW(2)) bus ();
    xor_unit_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .IDW(2)) bus2 ();

    xor_unit_arbiter #(.NUM_REQ(4), .WIDTH(32), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .op_count(op_count)
    );

    xor_unit_arbiter #(.NUM_REQ(4), .WIDTH(32), .IDW(2), .CNTW(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .busy(busy2), .op_count(op_count2)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d data %0h, expected none",
                         bus.resp_id, bus.resp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_id", 64'(bus.resp_id), 64'(e.id));
                check("resp_data", 64'(bus.resp_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        bus.req_inv    = 4'b1000;
        bus.req_a[0*32 +: 32] = 32'hAAAA5555; bus.req_b[0*32 +: 32] = 32'h0000FFFF;
        bus.req_a[1*32 +: 32] = 32'h12345678; bus.req_b[1*32 +: 32] = 32'h00000000;
        bus.req_a[2*32 +: 32] = 32'hFFFF0000; bus.req_b[2*32 +: 32] = 32'h0F0F0F0F;
        bus.req_a[3*32 +: 32] = 32'h00000000; bus.req_b[3*32 +: 32] = 32'h00000000;
        bus2.req_valid  = 4'b0000;
        bus2.resp_ready = 1'b1;
        bus2.req_inv    = 4'b0000;
        bus2.req_a      = '0;
        bus2.req_b      = '0;

        // Reset held with all requesters active.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", 64'(bus.req_ready), 64'h0);
            check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
            check("rst_op_count", 64'(op_count), 64'h0);
        end

        // Release: round robin 0,1,2,3,0,1 back to back.
        push(2'd0, 32'hAAAAAAAA);
        push(2'd1, 32'h12345678);
        push(2'd2, 32'hF0F00F0F);
        push(2'd3, 32'hFFFFFFFF);
        push(2'd0, 32'hAAAAAAAA);
        push(2'd1, 32'h12345678);
        reset_n = 1'b1;
        #1;
        check("first_grant", 64'(bus.req_ready), 64'h1);
        for (int i = 0; i < 6; i++) tick();
        bus.req_valid = 4'b0000;
        tick();
        check("rr_op_count", 64'(op_count), 64'd6);
        check("rr_idle", 64'(bus.resp_valid), 64'h0);
        check("rr_drained", 64'(exp_q.size()), 64'h0);

        // Single XOR from requester 2.
        push(2'd2, 32'hF0F00F0F);
        bus.req_valid = 4'b0100;
        #1;
        check("xor_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = 4'b0000;
        check("xor_valid", 64'(bus.resp_valid), 64'h1);
        check("xor_data", 64'(bus.resp_data), 64'hF0F00F0F);
        check("xor_id", 64'(bus.resp_id), 64'd2);
        tick();
        bus.req_valid = 4'b1111;
        #1;
        check("ptr_after_xor", 64'(bus.req_ready), 64'h8);
        bus.req_valid = 4'b0000;

        // XNOR from requester 1.
        bus.req_a[1*32 +: 32] = 32'h12345678;
        bus.req_b[1*32 +: 32] = 32'h12345678;
        bus.req_inv = 4'b1010;
        push(2'd1, 32'hFFFFFFFF);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        check("xnor_data", 64'(bus.resp_data), 64'hFFFFFFFF);
        check("xnor_id", 64'(bus.resp_id), 64'd1);
        tick();

        // Backpressure: response from requester 0 held while requester 3 waits.
        bus.resp_ready = 1'b0;
        push(2'd0, 32'hAAAAAAAA);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b1000;
        push(2'd3, 32'hFFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", 64'(bus.req_ready), 64'h0);
            check("bp_valid", 64'(bus.resp_valid), 64'h1);
            check("bp_data", 64'(bus.resp_data), 64'hAAAAAAAA);
            check("bp_id", 64'(bus.resp_id), 64'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release_grant", 64'(bus.req_ready), 64'h8);
        tick();
        bus.req_valid = 4'b0000;
        check("bp_next_valid", 64'(bus.resp_valid), 64'h1);
        check("bp_next_id", 64'(bus.resp_id), 64'd3);
        check("bp_next_data", 64'(bus.resp_data), 64'hFFFFFFFF);
        tick();
        check("bp_op_count", 64'(op_count), 64'd10);

        // Reset while a response is held; it is discarded.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        check("mid_hold", 64'(bus.resp_valid), 64'h1);
        reset_n = 1'b0;
        #1;
        bus.req_valid = 4'b1111;
        #1;
        check("mid_rst_ready", 64'(bus.req_ready), 64'h0);
        bus.req_valid = 4'b0000;
        tick();
        reset_n = 1'b1;
        check("mid_rst_valid", 64'(bus.resp_valid), 64'h0);
        check("mid_rst_data", 64'(bus.resp_data), 64'h0);
        check("mid_rst_id", 64'(bus.resp_id), 64'h0);
        check("mid_rst_count", 64'(op_count), 64'h0);
        bus.req_valid = 4'b1111;
        #1;
        check("mid_rst_ptr", 64'(bus.req_ready), 64'h1);
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;

        // Saturation on the 4-bit counter instance: 20 completions.
        bus2.req_valid = 4'b1111;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 15) check("sat_14", 64'(op_count2), 64'hE);
        end
        bus2.req_valid = 4'b0000;
        check("sat_final", 64'(op_count2), 64'hF);
        tick();
        check("sat_hold", 64'(op_count2), 64'hF);
        check("final_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_unit_arbiter.md
Name: xor_unit_arbiter

Overview:
- Shares one 32-bit bitwise XOR datapath between NUM_REQ requesters inside the ALU logic section.
- Grants the datapath round-robin, one operation per grant, and registers the result with a valid/ready response handshake.
- Supports an optional inverted result (XNOR) per request.
- Keeps a saturating count of completed operations for debug.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..8
WIDTH, 32, operand and result width in bits
IDW, 2, requester id width; equals log2(NUM_REQ)
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset_n  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  bit i set: requester i presents an operation
req_ready  output  NUM_REQ  one-hot or zero; bit i set: requester i is granted this cycle
req_a  input  NUM_REQ*WIDTH  flat operand A; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  flat operand B; same packing as req_a
req_inv  input  NUM_REQ  bit i set: requester i wants the inverted XOR (XNOR)
resp_valid  output  1  resp_data and resp_id are valid
resp_ready  input  1  consumer accepts the response
resp_data  output  WIDTH  registered result
resp_id  output  IDW  index of the requester that produced resp_data
busy  output  1  equals resp_valid
op_count  output  CNTW  number of completed operations; saturates at all-ones

Behaviour:
- Reset (reset_n low at a clock edge): regardless of any activity in progress:
  - resp_valid=0, resp_data=0, resp_id=0, op_count=0.
  - Round-robin pointer ptr=0; state=IDLE.
  - A pending response is discarded.
  - req_ready is 0 whenever reset_n is low.
- States:
  - IDLE: no response held.
  - HOLD: response held, resp_valid=1.
- Accept condition: acc = (state==IDLE) or (state==HOLD and resp_ready).
- Grant (combinational):
  - When acc=1, g = the first index with req_valid set, scanning ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - If no req_valid bit is set, or acc=0, req_ready is all zero.
  - req_ready depends on req_valid, but requesters must not make req_valid depend on req_ready.
- Transfer: occurs when req_valid[g] and req_ready[g] are both set. At the next edge:
  - resp_data = (A_g XOR B_g), inverted bitwise if req_inv[g].
  - resp_id = g; resp_valid=1; state=HOLD.
  - ptr = (g+1) mod NUM_REQ.
  - Latency: one cycle from transfer to resp_valid.
- Response handshake:
  - While in HOLD with resp_ready=0: resp_valid, resp_data and resp_id hold stable, and no grant is issued.
  - Completion = resp_valid and resp_ready at an edge.
  - On completion with a simultaneous new transfer: HOLD is kept and new data loads. Sustained throughput is one operation per cycle.
  - On completion without a transfer: state becomes IDLE and resp_valid becomes 0. resp_data and resp_id keep their last values.
- op_count increments by 1 on each completion and stops at 2^CNTW-1.
- ptr changes only on a transfer. A requester that drops req_valid before it is granted is simply skipped; this is not an error.
- Arithmetic: the XOR is purely bitwise and WIDTH-wide. There is no carry and no flag output.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset_n=0 for 3 cycles, with req_valid=4'b1111 and resp_ready=1.
  - Response: req_ready=0, resp_valid=0, op_count=0 throughout.
  - After release: the first grant goes to requester 0.
- Single XOR:
  - Stimulus: req 2 with A=32'hFFFF0000, B=32'h0F0F0F0F, inv=0.
  - Response: next cycle resp_valid=1, resp_data=32'hF0F00F0F, resp_id=2.
  - Then ptr=3.
- XNOR:
  - Stimulus: req 1 with A=32'h12345678, B=32'h12345678, inv=1.
  - Response: resp_data=32'hFFFFFFFF, resp_id=1.
- Round-robin fairness:
  - Stimulus: all four requesters valid continuously, resp_ready=1.
  - Response: resp_id sequence 0,1,2,3,0,1; one result per cycle; op_count=6 after 6 completions.
- Backpressure:
  - Stimulus: response held with resp_ready=0 for 5 cycles while req 3 is valid.
  - Response: resp_data and resp_id stable, req_ready=0.
  - When resp_ready rises: req 3 is granted in that same cycle, and its result appears on the next cycle.
- Mid-operation reset and saturation:
  - Stimulus: assert reset_n=0 while HOLD with resp_ready=0.
  - Response: the next cycle shows resp_valid=0 and ptr=0.
  - Separately, with CNTW=4 and 20 completions: op_count stops at 4'hF.
